// File: rtl/seq_pkg.sv
// Shared types and default constants for the serial pattern transmitter.
package seq_pkg;

  // Transmitter control states. The S_ prefix keeps the names clear of the
  // GAP parameter that every user of this package also declares.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2,
    S_DONE  = 2'd3
  } seq_state_t;

  localparam int SEQ_WIDTH = 8;
  localparam int SEQ_GAP   = 2;

endpackage

// File: rtl/seq_shift_ctr.sv
// Loadable down-counter with a terminal-count flag. It saturates at zero
// instead of wrapping. Used for the bit index, the repeat count and the gap count.
module seq_shift_ctr #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         tc
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: a load wins over a decrement, and a decrement stops at zero.
  always_comb begin
    // NOTE: give every always_comb output a default first; a path that leaves it unassigned infers a latch.
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  // Count register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: flops take non-blocking (<=) so every register samples pre-edge values regardless of block order.
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign tc    = (count_q == '0);

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial bit-pattern transmitter. It accepts a pattern, a length and a repeat
// count through a valid/ready handshake. It shifts the active field out
// MSB-first, with GAP idle cycles between repetitions. A one-cycle done pulse
// follows the final bit.
module seq_pattern_tx
  import seq_pkg::*;
#(
  parameter int WIDTH = SEQ_WIDTH,
  parameter int LEN_W = $clog2(WIDTH) + 1,
  parameter int REP_W = 4,
  parameter int GAP   = SEQ_GAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic [REP_W-1:0] rep,
  output logic             dout,
  output logic             dout_valid,
  output logic             busy,
  output logic             done
);

  localparam int IDX_W  = $clog2(WIDTH);
  localparam int GAP_W  = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int GAP_M1 = (GAP > 0) ? GAP - 1 : 0;
  localparam logic [LEN_W-1:0] WIDTH_L = LEN_W'(WIDTH);
  localparam logic [GAP_W-1:0] GAP_LD  = GAP_W'(GAP_M1);

  seq_state_t       state_q, state_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] len_eff;

  logic             dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             load_ready_q, load_ready_d;

  logic             idx_load, idx_dec, idx_tc;
  logic [IDX_W-1:0] idx_load_val, idx_q, dout_sel;
  logic             rep_load, rep_dec, rep_tc;
  logic [REP_W-1:0] rep_cnt;
  logic             gap_load, gap_dec, gap_tc;
  logic [GAP_W-1:0] gap_cnt;

  // Position of the next bit to send, counting down to 0.
  seq_shift_ctr #(.W(IDX_W)) u_idx_ctr (
    .clk      (clk),
    .rst      (rst),
    .load     (idx_load),
    .load_val (idx_load_val),
    .dec      (idx_dec),
    .count    (idx_q),
    .tc       (idx_tc)
  );

  // Repetitions still owed after the current one.
  seq_shift_ctr #(.W(REP_W)) u_rep_ctr (
    .clk      (clk),
    .rst      (rst),
    .load     (rep_load),
    .load_val (rep),
    .dec      (rep_dec),
    .count    (rep_cnt),
    .tc       (rep_tc)
  );

  // Idle cycles left in the current inter-repeat gap.
  seq_shift_ctr #(.W(GAP_W)) u_gap_ctr (
    .clk      (clk),
    .rst      (rst),
    .load     (gap_load),
    .load_val (GAP_LD),
    .dec      (gap_dec),
    .count    (gap_cnt),
    .tc       (gap_tc)
  );

  // A length of zero or above WIDTH means "send the whole word".
  assign len_eff = ((len == '0) || (len > WIDTH_L)) ? WIDTH_L : len;

  // Next-state, counter control, and next values of the registered outputs.
  always_comb begin
    state_d      = state_q;
    pat_d        = pat_q;
    len_d        = len_q;
    idx_load     = 1'b0;
    idx_load_val = IDX_W'(len_q - 1'b1);
    idx_dec      = 1'b0;
    rep_load     = 1'b0;
    rep_dec      = 1'b0;
    gap_load     = 1'b0;
    gap_dec      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (load_valid && load_ready_q) begin
          state_d      = S_SHIFT;
          pat_d        = pattern;
          len_d        = len_eff;
          idx_load     = 1'b1;
          idx_load_val = IDX_W'(len_eff - 1'b1);
          rep_load     = 1'b1;
        end
      end
      S_SHIFT: begin
        if (!idx_tc) begin
          idx_dec = 1'b1;
        end else if (rep_tc) begin
          state_d = S_DONE;
        end else begin
          rep_dec = 1'b1;
          if (GAP > 0) begin
            gap_load = 1'b1;
            state_d  = S_GAP;
          end else begin
            idx_load = 1'b1;
          end
        end
      end
      S_GAP: begin
        if (gap_tc) begin
          state_d  = S_SHIFT;
          idx_load = 1'b1;
        end else begin
          gap_dec = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are registered, so they follow the state being entered.
    dout_sel     = idx_load ? idx_load_val : (idx_q - 1'b1);
    dout_valid_d = (state_d == S_SHIFT);
    dout_d       = dout_valid_d & pat_d[dout_sel];
    busy_d       = (state_d == S_SHIFT) || (state_d == S_GAP);
    done_d       = (state_d == S_DONE);
    load_ready_d = (state_d == S_IDLE);
  end

  // State, captured request and output registers. A reset aborts any request immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      // NOTE: the captured pattern and length are reset too. This is cheap at this size and keeps the reset state fully defined.
      pat_q        <= '0;
      len_q        <= '0;
      dout_q       <= 1'b0;
      dout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      load_ready_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      pat_q        <= pat_d;
      len_q        <= len_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      load_ready_q <= load_ready_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign load_ready = load_ready_q;

  a_idx_in_range: assert property (@(posedge clk) disable iff (rst)
    (state_q == S_SHIFT) |-> (LEN_W'(idx_q) < len_q));

  a_shift_exit_at_bit0: assert property (@(posedge clk) disable iff (rst)
    ((state_q == S_SHIFT) && (state_d != S_SHIFT)) |-> idx_tc);

  a_gap_in_range: assert property (@(posedge clk) disable iff (rst)
    (state_q == S_GAP) |-> (gap_cnt <= GAP_LD));

  a_rep_no_wrap: assert property (@(posedge clk) disable iff (rst)
    rep_dec |-> (rep_cnt != '0));

endmodule
